// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: parity mode, receiver FSM states and the
// 2-of-3 majority vote used for every bit decision.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rxd line plus a falling-edge
// detector on the synchronised value. All flops reset to the idle level (1).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd_i,
  output logic rxd_s_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: non-blocking assignments make each flop take the pre-edge value of
  // its neighbour; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rxd_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rxd_s_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with 3-sample majority voting, optional parity and 1-2 stop bits.
// Define UART_RX_BREAK_EN to report an all-zero frame on rx_break instead of rx_done.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 200_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter parity_e     PARITY    = PAR_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_break
);

  localparam int unsigned DIV = (BAUD == 0) ? 0 : CLK_HZ / BAUD;
  localparam int unsigned CW  = (DIV < 2) ? 1 : $clog2(DIV);

  localparam logic [CW-1:0] CNT_S0    = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_S1    = CW'(DIV / 2);
  localparam logic [CW-1:0] CNT_S2    = CW'(DIV / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  if (BAUD == 0 || DIV < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY > PAR_ODD) begin : g_bad_param
    $error("uart_rx_ext: illegal parameter set");
  end

  logic rxd_s;
  logic rxd_fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rxd_i   (rxd),
    .rxd_s_o (rxd_s),
    .fall_o  (rxd_fall)
  );

  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           bit_q;
  logic                 stop_q;
  logic [1:0]           smp_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 ferr_acc_q;
  logic                 perr_acc_q;
  logic                 any_one_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q;
  logic                 busy_q;
  logic                 frame_err_q;
  logic                 parity_err_q;
  logic                 brk_q;

  logic in_bit;
  logic at_s2;
  logic at_last;
  logic bit_val;
  logic brk_hit;

  assign in_bit  = state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
  assign at_s2   = (cnt_q == CNT_S2);
  assign at_last = (cnt_q == CNT_LAST);
  // Third sample is taken live so the vote is ready in the same cycle.
  assign bit_val = maj3(smp_q[0], smp_q[1], rxd_s);

`ifdef UART_RX_BREAK_EN
  assign brk_hit = ~(any_one_q | bit_val);
`else
  assign brk_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      smp_q        <= 2'b11;
      shift_q      <= '0;
      ferr_acc_q   <= 1'b0;
      perr_acc_q   <= 1'b0;
      any_one_q    <= 1'b0;
      data_q       <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      brk_q  <= 1'b0;

      if (in_bit) begin
        if (cnt_q == CNT_S0) smp_q[0] <= rxd_s;
        if (cnt_q == CNT_S1) smp_q[1] <= rxd_s;
        cnt_q <= at_last ? '0 : cnt_q + 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (rxd_fall) begin
            state_q    <= ST_START;
            cnt_q      <= CW'(1);
            bit_q      <= '0;
            stop_q     <= 1'b0;
            ferr_acc_q <= 1'b0;
            perr_acc_q <= 1'b0;
            any_one_q  <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        ST_START: begin
          if (at_s2 && bit_val) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (at_last) begin
            state_q <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (at_s2) begin
            shift_q   <= {bit_val, shift_q[DATA_BITS-1:1]};
            any_one_q <= any_one_q | bit_val;
          end
          if (at_last) begin
            if (bit_q == BIT_LAST) begin
              state_q <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (at_s2) begin
            perr_acc_q <= (^{shift_q, bit_val}) != (PARITY == PAR_ODD);
            any_one_q  <= any_one_q | bit_val;
          end
          if (at_last) state_q <= ST_STOP;
        end

        ST_STOP: begin
          if (at_s2) begin
            ferr_acc_q <= ferr_acc_q | ~bit_val;
            any_one_q  <= any_one_q | bit_val;
            if (stop_q == STOP_LAST) begin
              cnt_q  <= '0;
              busy_q <= 1'b0;
              if (brk_hit) begin
                brk_q   <= 1'b1;
                state_q <= ST_BREAK;
              end else begin
                data_q       <= shift_q;
                frame_err_q  <= ferr_acc_q | ~bit_val;
                parity_err_q <= perr_acc_q;
                done_q       <= 1'b1;
                state_q      <= ST_IDLE;
              end
            end
          end else if (at_last) begin
            stop_q <= 1'b1;
          end
        end

        ST_BREAK: begin
          // Leave only after one full bit time of continuous idle level.
          if (!rxd_s) begin
            cnt_q <= '0;
          end else if (at_last) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data       = data_q;
  assign rx_done       = done_q;
  assign rx_busy       = busy_q;
  assign rx_frame_err  = frame_err_q;
  assign rx_parity_err = parity_err_q;
  assign rx_break      = brk_q;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext: 8N1, 8E1 and 8N2 receivers at DIV=16,
// directed corner cases plus random frames checked against a frame-level model.
module tb_uart_rx_ext;
  import uart_pkg::*;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = CLK_HZ / BAUD;

`ifdef UART_RX_BREAK_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rxd_l = 3'b111;
  logic [7:0] data_w [3];
  logic [2:0] done_w, busy_w, ferr_w, perr_w, brk_w;

  int n_checks = 0;
  int n_errors = 0;
  int brk_cnt [3] = '{default: 0};
  logic [7:0] last_data [3] = '{default: 8'h00};
  logic [9:0] obs_q0 [$];
  logic [9:0] obs_q1 [$];
  logic [9:0] obs_q2 [$];

  always #5 clk = ~clk;

  uart_rx_ext #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) dut_n1 (
    .clk(clk), .rst(rst), .rxd(rxd_l[0]), .rx_data(data_w[0]), .rx_done(done_w[0]),
    .rx_busy(busy_w[0]), .rx_frame_err(ferr_w[0]), .rx_parity_err(perr_w[0]), .rx_break(brk_w[0]));

  uart_rx_ext #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut_e1 (
    .clk(clk), .rst(rst), .rxd(rxd_l[1]), .rx_data(data_w[1]), .rx_done(done_w[1]),
    .rx_busy(busy_w[1]), .rx_frame_err(ferr_w[1]), .rx_parity_err(perr_w[1]), .rx_break(brk_w[1]));

  uart_rx_ext #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(2)) dut_n2 (
    .clk(clk), .rst(rst), .rxd(rxd_l[2]), .rx_data(data_w[2]), .rx_done(done_w[2]),
    .rx_busy(busy_w[2]), .rx_frame_err(ferr_w[2]), .rx_parity_err(perr_w[2]), .rx_break(brk_w[2]));

  // Every cycle a strobe is high counts as one event, so a stretched strobe shows up.
  always @(negedge clk) begin
    if (done_w[0]) obs_q0.push_back({data_w[0], ferr_w[0], perr_w[0]});
    if (done_w[1]) obs_q1.push_back({data_w[1], ferr_w[1], perr_w[1]});
    if (done_w[2]) obs_q2.push_back({data_w[2], ferr_w[2], perr_w[2]});
    for (int c = 0; c < 3; c++) if (brk_w[c]) brk_cnt[c]++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic take(input int ch, output int n, output logic [9:0] o);
    o = '0;
    n = 0;
    case (ch)
      0: begin n = obs_q0.size(); if (n > 0) o = obs_q0.pop_front(); end
      1: begin n = obs_q1.size(); if (n > 0) o = obs_q1.pop_front(); end
      default: begin n = obs_q2.size(); if (n > 0) o = obs_q2.pop_front(); end
    endcase
  endtask

  task automatic drive_bit(input int ch, input logic v, input int spike);
    for (int j = 0; j < DIV; j++) begin
      rxd_l[ch] = (j == spike) ? ~v : v;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input int ch, input logic [7:0] d, input logic has_par, input logic par,
                            input int nst, input logic [1:0] stops, input int spike_bit);
    drive_bit(ch, 1'b0, -1);
    for (int i = 0; i < 8; i++) drive_bit(ch, d[i], (i == spike_bit) ? DIV / 2 : -1);
    if (has_par) drive_bit(ch, par, -1);
    for (int s = 0; s < nst; s++) drive_bit(ch, stops[s], -1);
    rxd_l[ch] = 1'b1;
  endtask

  // Channel 0 is 8N1, channel 1 is 8E1, channel 2 is 8N2.
  task automatic run_frame(input int ch, input logic [7:0] d, input logic par, input logic [1:0] stops,
                           input int spike_bit, input int gap, input string tag);
    logic has_par, exp_ferr, exp_perr, is_brk, brk_exp;
    int nst, b0, n;
    logic [9:0] o;
    has_par = (ch == 1);
    nst     = (ch == 2) ? 2 : 1;
    b0      = brk_cnt[ch];
    send_frame(ch, d, has_par, par, nst, stops, spike_bit);
    repeat (gap) @(negedge clk);

    exp_ferr = !stops[0] || (nst == 2 && !stops[1]);
    exp_perr = has_par && ((($countones(d) + int'(par)) % 2) != 0);
    is_brk   = (d == 8'h00) && !(has_par && par) && (nst == 1 ? !stops[0] : stops == 2'b00);
    brk_exp  = is_brk && BRK_EN;
    if (!brk_exp) last_data[ch] = d;

    take(ch, n, o);
    check({tag, "_brk"},   brk_cnt[ch] - b0, {31'b0, brk_exp});
    check({tag, "_ndone"}, n,                {31'b0, !brk_exp});
    check({tag, "_data"},  o[9:2],           brk_exp ? 8'h00 : d);
    check({tag, "_ferr"},  o[1],             brk_exp ? 1'b0 : exp_ferr);
    check({tag, "_perr"},  o[0],             brk_exp ? 1'b0 : exp_perr);
    check({tag, "_hold"},  data_w[ch],       last_data[ch]);
    check({tag, "_busy"},  busy_w[ch],       0);
  endtask

  initial begin
    int n, b0;
    logic [9:0] o;
    logic saw_busy;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data0", data_w[0], 0);
    check("rst_data1", data_w[1], 0);
    check("rst_data2", data_w[2], 0);
    check("rst_done",  done_w, 0);
    check("rst_busy",  busy_w, 0);
    check("rst_ferr",  ferr_w, 0);
    check("rst_perr",  perr_w, 0);
    check("rst_brk",   brk_w, 0);

    // Reset in the middle of a frame must abort it silently.
    rxd_l[0] = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    check("abort_busy_pre", busy_w[0], 1);
    rst = 1'b1;
    rxd_l[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12 * DIV) @(negedge clk);
    take(0, n, o);
    check("abort_ndone", n, 0);
    check("abort_busy", busy_w[0], 0);

    // A 4-clock low glitch starts a frame but the start-bit vote rejects it.
    saw_busy = 1'b0;
    rxd_l[0] = 1'b0;
    repeat (4) begin @(negedge clk); saw_busy |= busy_w[0]; end
    rxd_l[0] = 1'b1;
    repeat (10) begin @(negedge clk); saw_busy |= busy_w[0]; end
    check("glitch_saw_busy", saw_busy, 1);
    check("glitch_busy", busy_w[0], 0);
    repeat (2 * DIV) @(negedge clk);
    take(0, n, o);
    check("glitch_ndone", n, 0);

    run_frame(0, 8'hA5, 1'b0, 2'b11, -1, DIV, "n1_a5");
    run_frame(1, 8'h03, 1'b1, 2'b11, -1, DIV, "e1_par1");
    run_frame(1, 8'h03, 1'b0, 2'b11, -1, DIV, "e1_par0");
    run_frame(2, 8'h5A, 1'b0, 2'b01, -1, DIV, "n2_stop2lo");
    run_frame(0, 8'hFF, 1'b0, 2'b11,  3, DIV, "n1_spike");
    run_frame(0, 8'h11, 1'b0, 2'b11, -1, 0,   "b2b_first");
    run_frame(0, 8'h22, 1'b0, 2'b11, -1, DIV, "b2b_second");

    // Line held low for 20 bit times.
    b0 = brk_cnt[0];
    rxd_l[0] = 1'b0;
    repeat (20 * DIV) @(negedge clk);
    rxd_l[0] = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    take(0, n, o);
    check("brk20_brk",   brk_cnt[0] - b0, {31'b0, BRK_EN});
    check("brk20_ndone", n, {31'b0, !BRK_EN});
    check("brk20_data",  o[9:2], 0);
    check("brk20_ferr",  o[1], {31'b0, !BRK_EN});
    check("brk20_perr",  o[0], 0);
    check("brk20_busy",  busy_w[0], 0);
    if (!BRK_EN) last_data[0] = 8'h00;
    run_frame(0, 8'h3C, 1'b0, 2'b11, -1, DIV, "after_brk");

    for (int k = 0; k < 24; k++) begin
      int ch;
      logic [7:0] d;
      logic [1:0] st;
      ch = $urandom_range(0, 2);
      d  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      run_frame(ch, d, 1'($urandom), st, -1, DIV + 4, $sformatf("rnd%0d_ch%0d", k, ch));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
